// File: rtl/bcd_down_counter.sv
// bcd_down_counter: synchronous mod-10 down counter with DIGITS cascaded decades.
// It supports parallel load with per-digit clamp to 9 and a decrement on enable.
// The combinational borrow output flags the cycle whose edge wraps the count, so it
// can drive the enable of a higher cascaded stage.
// Optional feature macro: BCD_DOWN_RELOAD_EN. When it is defined, the counter reloads
// from load_val at terminal count instead of wrapping to all 9s. This gives a
// free-running divide-by-(N+1).
module bcd_down_counter #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] q,
    output logic                zero,
    output logic                borrow
);

    localparam int W = 4 * DIGITS;

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("bcd_down_counter: DIGITS must be in 1..8");
    end

    // lower_zero[i] is high when every digit below i is 0.
    // This means digit i decrements this cycle. lower_zero[DIGITS] is the
    // all-zero decode.
    logic [DIGITS:0] lower_zero;
    logic [W-1:0]    load_clamped;
    logic [W-1:0]    q_dec;
    logic [W-1:0]    q_next;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [3:0] dec_digit(input logic [3:0] d);
        return (d == 4'd0) ? 4'd9 : (d - 4'd1);
    endfunction

    assign lower_zero[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] cur;
        assign cur                    = q[4*i +: 4];
        assign lower_zero[i+1]        = lower_zero[i] & (cur == 4'd0);
        assign load_clamped[4*i +: 4] = clamp_digit(load_val[4*i +: 4]);
        assign q_dec[4*i +: 4]        = lower_zero[i] ? dec_digit(cur) : cur;
    end

    assign zero = lower_zero[DIGITS];

    // Next count on an enabled, non-load cycle.
    // Plain decrement already wraps 0 -> all 9s.
    always_comb begin
        q_next = q_dec;
`ifdef BCD_DOWN_RELOAD_EN
        if (zero) begin
            q_next = load_clamped;
        end
`else
`endif
    end

    // Count register: reset > load > enable > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_clamped;
        end else if (en) begin
            q <= q_next;
        end
    end

    assign borrow = en & ~load & ~rst & zero;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Scoreboard bench for bcd_down_counter.
// It uses a DIGITS=2 instance and a DIGITS=1 instance.
// Each directed step pushes the hand-computed expectation for that cycle.
// A negedge monitor pops the expectation and compares it against the selected instance.
module tb_bcd_down_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef BCD_DOWN_RELOAD_EN
    localparam logic [7:0] WRAP2 = 8'h01;
    localparam logic [7:0] W1A   = 8'h03;
    localparam logic [7:0] W1B   = 8'h02;
`else
    localparam logic [7:0] WRAP2 = 8'h99;
    localparam logic [7:0] W1A   = 8'h09;
    localparam logic [7:0] W1B   = 8'h08;
`endif

    logic       rst2, en2, load2, zero2, borrow2;
    logic [7:0] lv2, q2;
    logic       rst1, en1, load1, zero1, borrow1;
    logic [3:0] lv1, q1;

    bcd_down_counter #(.DIGITS(2)) u_dut2 (
        .clk(clk), .rst(rst2), .en(en2), .load(load2),
        .load_val(lv2), .q(q2), .zero(zero2), .borrow(borrow2)
    );

    bcd_down_counter #(.DIGITS(1)) u_dut1 (
        .clk(clk), .rst(rst1), .en(en1), .load(load1),
        .load_val(lv1), .q(q1), .zero(zero1), .borrow(borrow1)
    );

    typedef struct {
        bit         sel;
        logic [7:0] eq;
        logic       eb;
        int         idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_n  = 0;

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL vec%0d %s: actual=%h required=%h", idx, name, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!e.sel) begin
                check("d2_q",      e.idx, q2, e.eq);
                check("d2_zero",   e.idx, {7'd0, zero2},   {7'd0, (e.eq == 8'h00)});
                check("d2_borrow", e.idx, {7'd0, borrow2}, {7'd0, e.eb});
            end else begin
                check("d1_q",      e.idx, {4'd0, q1},      {4'd0, e.eq[3:0]});
                check("d1_zero",   e.idx, {7'd0, zero1},   {7'd0, (e.eq[3:0] == 4'd0)});
                check("d1_borrow", e.idx, {7'd0, borrow1}, {7'd0, e.eb});
            end
        end
    end

    // Apply inputs just after an edge.
    // The expected value is the registered q from that edge plus borrow for the new inputs.
    task automatic step(input bit sel, input logic r, input logic e, input logic l,
                        input logic [7:0] lv, input logic [7:0] eq, input logic eb);
        exp_t x;
        @(posedge clk);
        #1;
        if (!sel) begin
            rst2 = r; en2 = e; load2 = l; lv2 = lv;
        end else begin
            rst1 = r; en1 = e; load1 = l; lv1 = lv[3:0];
        end
        x.sel = sel; x.eq = eq; x.eb = eb; x.idx = vec_n;
        exp_q.push_back(x);
        vec_n++;
    endtask

    initial begin
        rst2 = 1'b1; en2 = 1'b1; load2 = 1'b1; lv2 = 8'h45;
        rst1 = 1'b1; en1 = 1'b0; load1 = 1'b0; lv1 = 4'h0;

        //     sel r  e  l  lv     exp_q  borrow
        step(0, 1, 1, 1, 8'h45, 8'h00, 0);   // reset with en/load asserted
        step(0, 1, 1, 1, 8'h45, 8'h00, 0);
        step(0, 0, 0, 1, 8'h23, 8'h00, 0);   // load 23
        step(0, 0, 1, 0, 8'h23, 8'h23, 0);
        step(0, 0, 1, 0, 8'h23, 8'h22, 0);
        step(0, 0, 1, 0, 8'h23, 8'h21, 0);
        step(0, 0, 1, 0, 8'h23, 8'h20, 0);
        step(0, 0, 0, 0, 8'h23, 8'h19, 0);   // hold
        step(0, 0, 0, 1, 8'h01, 8'h19, 0);   // load 01
        step(0, 0, 1, 0, 8'h01, 8'h01, 0);
        step(0, 0, 1, 0, 8'h01, 8'h00, 1);   // wrap edge
        step(0, 0, 0, 1, 8'h00, WRAP2, 0);   // load 00
        step(0, 0, 1, 1, 8'h5C, 8'h00, 0);   // load beats en at zero, clamp
        step(0, 0, 0, 0, 8'h5C, 8'h59, 0);
        step(0, 0, 1, 1, 8'h57, 8'h59, 0);   // load 57
        step(0, 0, 1, 0, 8'h57, 8'h57, 0);
        step(0, 0, 1, 0, 8'h57, 8'h56, 0);
        step(0, 1, 1, 0, 8'h57, 8'h55, 0);   // reset mid-count
        step(0, 0, 0, 0, 8'h57, 8'h00, 0);   // hold at zero
        step(0, 0, 0, 0, 8'h57, 8'h00, 0);
        step(0, 1, 1, 0, 8'h57, 8'h00, 0);   // reset masks borrow at zero
        step(0, 0, 0, 1, 8'hA0, 8'h00, 0);   // clamp upper digit
        step(0, 0, 0, 0, 8'hA0, 8'h90, 0);
        step(0, 0, 1, 0, 8'hA0, 8'h90, 0);
        step(0, 0, 1, 0, 8'hA0, 8'h89, 0);
        step(0, 0, 0, 0, 8'hA0, 8'h88, 0);

        // DIGITS=1 instance
        step(1, 0, 0, 1, 8'h03, 8'h00, 0);
        step(1, 0, 1, 0, 8'h03, 8'h03, 0);
        step(1, 0, 1, 0, 8'h03, 8'h02, 0);
        step(1, 0, 1, 0, 8'h03, 8'h01, 0);
        step(1, 0, 1, 0, 8'h03, 8'h00, 1);
        step(1, 0, 1, 0, 8'h03, W1A,   0);
        step(1, 0, 0, 0, 8'h03, W1B,   0);
        step(1, 0, 1, 1, 8'h0F, W1B,   0);   // clamp F -> 9
        step(1, 0, 0, 0, 8'h0F, 8'h09, 0);

        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
